// File: rtl/fetch_unit_pkg.sv
// Shared pipeline package: datapath widths, the bubble instruction word,
// the opcode field encoding and the register-index type used across stages.
package fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [PC_W-1:0]    PC_ONE    = 16'h0001;

    // Opcode lives in bits [15:12] of every instruction word
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LDI  = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_BNE  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JAL  = 4'hB,
        OP_JR   = 4'hC,
        OP_HALT = 4'hF
    } opcode_t;

    typedef logic [2:0] reg_idx_t;

    // Next sequential word address; wraps naturally at 2^PC_W
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_ONE;
    endfunction

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_t'(instr[15:12]);
    endfunction

endpackage

// File: rtl/fetch_unit_perf_counters.sv
// Fetch performance counters: delivered instructions, stall cycles and
// redirect (flush) cycles. All 32 bits wide, cleared by reset, free-wrapping.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetched_inc,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    // Each counter steps by one on the cycle its event is asserted
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
            perf_flush   <= 32'd0;
        end else begin
            if (fetched_inc) perf_fetched <= perf_fetched + 32'd1;
            if (stall_inc)   perf_stall   <= perf_stall + 32'd1;
            if (flush_inc)   perf_flush   <= perf_flush + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of a synchronous instruction memory.
// Owns the PC, hides the 1-cycle memory latency with an in-flight slot and
// registers the IF/ID outputs. Handles decode stalls and redirect/flush.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetched,
// perf_stall and perf_flush counter outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_pc_plus1,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
`endif
);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] infl_pc;
    logic            infl_valid;

    // While stalled, re-issue the in-flight address so the memory keeps
    // presenting the same word; a redirect always issues the live fetch_pc
    assign imem_addr = (stall && !redirect_valid) ? infl_pc : fetch_pc;

    // Fetch pipeline: reset > redirect (flush) > stall (hold) > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            infl_pc     <= RESET_PC;
            infl_valid  <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
            if_instr    <= NOP_INSTR;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_pc;
            infl_valid <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
        end else if (!stall) begin
            if_valid    <= infl_valid;
            if_pc       <= infl_pc;
            if_pc_plus1 <= pc_inc(infl_pc);
            if_instr    <= infl_valid ? imem_instr : NOP_INSTR;
            infl_pc     <= fetch_pc;
            infl_valid  <= 1'b1;
            fetch_pc    <= pc_inc(fetch_pc);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetched_inc;
    logic stall_inc;

    // Event strobes for the counters, derived from the same priority order
    always_comb begin
        fetched_inc = !redirect_valid && !stall && infl_valid;
        stall_inc   = stall && !redirect_valid;
    end

    fetch_perf_counters u_perf (
        .clk          (clk),
        .reset        (reset),
        .fetched_inc  (fetched_inc),
        .stall_inc    (stall_inc),
        .flush_inc    (redirect_valid),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
    );
`endif

endmodule
